// File: rtl/hdc_search_pkg.sv
// Shared types and width helpers for the Hamming-distance class search stage.
package hdc_search_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int class_id_w(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

    function automatic int frame_idx_w(input int num_frames);
        return (num_frames > 1) ? $clog2(num_frames) : 1;
    endfunction

    function automatic int dist_w(input int num_frames, input int frame_bits);
        return $clog2(num_frames * frame_bits + 1);
    endfunction

    localparam int DEF_FRAME_BITS  = 64;
    localparam int DEF_NUM_CLASSES = 8;
    localparam int DEF_NUM_FRAMES  = 3;
    localparam int DIST_W          = dist_w(DEF_NUM_FRAMES, DEF_FRAME_BITS);
    localparam int CLASS_ID_W      = class_id_w(DEF_NUM_CLASSES);
    localparam int FRAME_IDX_W     = frame_idx_w(DEF_NUM_FRAMES);

    typedef logic [DIST_W-1:0] dist_t;

endpackage

// File: rtl/hvec_popcount.sv
// Combinational binary adder-tree population count of one W-bit frame,
// zero-extended to OUT_W bits.
module hvec_popcount #(
    parameter int W     = 64,
    parameter int OUT_W = 8
) (
    input  logic [W-1:0]     vec,
    output logic [OUT_W-1:0] count
);

    localparam int LG    = (W > 1) ? $clog2(W) : 1;
    localparam int N     = 1 << LG;
    localparam int CNT_W = $clog2(W + 1);

    // Level 0 holds single bits (padded with zeros); each further level sums pairs.
    for (genvar l = 0; l <= LG; l++) begin : lvl
        logic [CNT_W-1:0] s [N >> l];
        for (genvar i = 0; i < (N >> l); i++) begin : nd
            if (l == 0) begin : leaf
                if (i < W) begin : bit_leaf
                    assign s[i] = CNT_W'(vec[i]);
                end else begin : pad_leaf
                    assign s[i] = '0;
                end
            end else begin : sum_node
                assign s[i] = lvl[l-1].s[2*i] + lvl[l-1].s[2*i+1];
            end
        end
    end

    assign count = OUT_W'(lvl[LG].s[0]);

endmodule

// File: rtl/hamming_class_search.sv
// Associative search: buffers a query hypervector, scans all class vectors frame by
// frame and reports the minimum-Hamming-distance class. Option: CLASS_SEARCH_MARGIN_EN.
module hamming_class_search
    import hdc_search_pkg::*;
#(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    localparam int CID_W  = class_id_w(NUM_CLASSES),
    localparam int FIDX_W = frame_idx_w(NUM_FRAMES),
    localparam int DW     = dist_w(NUM_FRAMES, DI_PARALLEL_W_BITS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          q_valid,
    output logic                          q_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] q_data,
    output logic [CID_W-1:0]              frame_id,
    output logic [FIDX_W-1:0]             frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [CID_W-1:0]              result_class,
    output logic [DW-1:0]                 result_dist
`ifdef CLASS_SEARCH_MARGIN_EN
    ,
    output logic [DW-1:0]                 result_margin
`endif
);

    localparam logic [FIDX_W-1:0] LAST_FRM = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [CID_W-1:0]  LAST_CLS = CID_W'(NUM_CLASSES - 1);

    state_t                          state_r, state_n;
    logic [DI_PARALLEL_W_BITS-1:0]   qbuf_r [NUM_FRAMES];
    logic [FIDX_W-1:0]               beat_cnt_r, beat_cnt_n, frm_r, frm_n;
    logic [CID_W-1:0]                cls_r, cls_n, best_cls_r, best_cls_n;
    logic [DW-1:0]                   acc_r, acc_n, best_dist_r, best_dist_n;
    logic [DW-1:0]                   second_r, second_n;
    logic                            q_ready_r, q_ready_n, busy_r, busy_n;
    logic                            res_valid_r, res_valid_n;
    logic [CID_W-1:0]                res_class_r, res_class_n;
    logic [DW-1:0]                   res_dist_r, res_dist_n, margin_r, margin_n;
    logic                            beat_take_s;
    logic [DI_PARALLEL_W_BITS-1:0]   diff_s;
    logic [DW-1:0]                   pop_s, dist_s;

    assign beat_take_s = (state_r == LOAD) && q_valid;
    assign diff_s      = qbuf_r[frm_r] ^ class_vec_in;
    assign dist_s      = acc_r + pop_s;

    hvec_popcount #(
        .W     (DI_PARALLEL_W_BITS),
        .OUT_W (DW)
    ) u_popcount (
        .vec   (diff_s),
        .count (pop_s)
    );

    // Next-state, counter, best-tracker and registered-output computation.
    always_comb begin
        state_n     = state_r;
        beat_cnt_n  = beat_cnt_r;
        frm_n       = frm_r;
        cls_n       = cls_r;
        acc_n       = acc_r;
        best_dist_n = best_dist_r;
        best_cls_n  = best_cls_r;
        second_n    = second_r;
        res_valid_n = res_valid_r;
        res_class_n = res_class_r;
        res_dist_n  = res_dist_r;
        margin_n    = margin_r;
        case (state_r)
            LOAD: begin
                if (q_valid) begin
                    if (beat_cnt_r == LAST_FRM) begin
                        state_n     = SCAN;
                        beat_cnt_n  = '0;
                        frm_n       = '0;
                        cls_n       = '0;
                        acc_n       = '0;
                        best_dist_n = '1;
                        best_cls_n  = '0;
                        second_n    = '1;
                    end else begin
                        beat_cnt_n = beat_cnt_r + FIDX_W'(1);
                    end
                end else begin
                    beat_cnt_n = beat_cnt_r;
                end
            end
            SCAN: begin
                if (frm_r != LAST_FRM) begin
                    acc_n = dist_s;
                    frm_n = frm_r + FIDX_W'(1);
                end else begin
                    acc_n = '0;
                    frm_n = '0;
                    // Strict compare keeps the lowest class id on ties.
                    if (dist_s < best_dist_r) begin
                        best_dist_n = dist_s;
                        best_cls_n  = cls_r;
                        second_n    = best_dist_r;
                    end else if (dist_s < second_r) begin
                        second_n = dist_s;
                    end else begin
                        second_n = second_r;
                    end
                    if (cls_r == LAST_CLS) begin
                        state_n     = DONE;
                        cls_n       = '0;
                        res_valid_n = 1'b1;
                        res_class_n = best_cls_n;
                        res_dist_n  = best_dist_n;
                        margin_n    = second_n - best_dist_n;
                    end else begin
                        cls_n = cls_r + CID_W'(1);
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_n     = LOAD;
                    res_valid_n = 1'b0;
                end else begin
                    res_valid_n = 1'b1;
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase
        q_ready_n = (state_n == LOAD);
        busy_n    = (state_n == SCAN);
    end

    // State, counters, accumulator, best tracker and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD;
            beat_cnt_r  <= '0;
            frm_r       <= '0;
            cls_r       <= '0;
            acc_r       <= '0;
            best_dist_r <= '1;
            best_cls_r  <= '0;
            second_r    <= '1;
            q_ready_r   <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_class_r <= '0;
            res_dist_r  <= '0;
            margin_r    <= '0;
            for (int i = 0; i < NUM_FRAMES; i++) begin
                qbuf_r[i] <= '0;
            end
        end else begin
            state_r     <= state_n;
            beat_cnt_r  <= beat_cnt_n;
            frm_r       <= frm_n;
            cls_r       <= cls_n;
            acc_r       <= acc_n;
            best_dist_r <= best_dist_n;
            best_cls_r  <= best_cls_n;
            second_r    <= second_n;
            q_ready_r   <= q_ready_n;
            busy_r      <= busy_n;
            res_valid_r <= res_valid_n;
            res_class_r <= res_class_n;
            res_dist_r  <= res_dist_n;
            margin_r    <= margin_n;
            if (beat_take_s) begin
                qbuf_r[beat_cnt_r] <= q_data;
            end
        end
    end

    assign q_ready      = q_ready_r;
    assign busy         = busy_r;
    assign frame_id     = cls_r;
    assign frame_index  = frm_r;
    assign result_valid = res_valid_r;
    assign result_class = res_class_r;
    assign result_dist  = res_dist_r;
`ifdef CLASS_SEARCH_MARGIN_EN
    assign result_margin = margin_r;
`endif

endmodule

// File: tb/tb_hamming_class_search.sv
// Directed and randomized checks of hamming_class_search against a software
// argmin-Hamming model driven by a bench-side class ROM.
module tb_hamming_class_search;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [63:0] q_data = 64'd0;
    logic [2:0]  frame_id;
    logic [1:0]  frame_index;
    logic [63:0] class_vec_in;
    logic        busy;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [2:0]  result_class;
    logic [7:0]  result_dist;
`ifdef CLASS_SEARCH_MARGIN_EN
    logic [7:0]  result_margin;
`endif

    logic [63:0] rom [8][3];
    logic [63:0] q [3];
    int          n_err = 0;
    int          n_chk = 0;
    int          exp_cls, exp_dist, exp_second;

    hamming_class_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .q_data       (q_data),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_dist  (result_dist)
`ifdef CLASS_SEARCH_MARGIN_EN
        ,
        .result_margin(result_margin)
`endif
    );

    always #5 clk = ~clk;

    assign class_vec_in = (frame_index < 2'd3) ? rom[frame_id][frame_index] : 64'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: Hamming distance to every class, strict argmin plus runner-up.
    task automatic model();
        int d;
        exp_dist   = 255;
        exp_second = 255;
        exp_cls    = 0;
        for (int c = 0; c < 8; c++) begin
            d = 0;
            for (int f = 0; f < 3; f++) d += $countones(q[f] ^ rom[c][f]);
            if (d < exp_dist) begin
                exp_second = exp_dist;
                exp_dist   = d;
                exp_cls    = c;
            end else if (d < exp_second) begin
                exp_second = d;
            end
        end
    endtask

    task automatic random_rom();
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 3; f++) rom[c][f] = rnd64();
    endtask

    task automatic send_query(input bit bubbles);
        for (int b = 0; b < 3; b++) begin
            if (bubbles) begin
                q_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    q_data = rnd64();
                    tick();
                end
            end
            q_valid = 1'b1;
            q_data  = q[b];
            tick();
        end
        q_valid = 1'b0;
    endtask

    // Sends the query, then checks latency, result and handshake against the model.
    task automatic run_query(input string tag, input bit bubbles, input bit do_ack);
        int cyc;
        model();
        send_query(bubbles);
        cyc = 1;
        while (!result_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd25);
        chk({tag, "_class"}, 64'(result_class), 64'(exp_cls));
        chk({tag, "_dist"}, 64'(result_dist), 64'(exp_dist));
`ifdef CLASS_SEARCH_MARGIN_EN
        chk({tag, "_margin"}, 64'(result_margin), 64'(exp_second - exp_dist));
`endif
        if (do_ack) begin
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            chk({tag, "_rv_clear"}, 64'(result_valid), 64'd0);
            chk({tag, "_qready_back"}, 64'(q_ready), 64'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_q_ready"}, 64'(q_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        chk({tag, "_result_class"}, 64'(result_class), 64'd0);
        chk({tag, "_result_dist"}, 64'(result_dist), 64'd0);
        chk({tag, "_frame_id"}, 64'(frame_id), 64'd0);
        chk({tag, "_frame_index"}, 64'(frame_index), 64'd0);
    endtask

    initial begin
        random_rom();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 1: query equals class 3 exactly.
        for (int f = 0; f < 3; f++) q[f] = rom[3][f];
        run_query("t1_exact", 1'b0, 1'b1);

        // 2: all classes identical, so the lowest id must win the tie.
        q[0] = rnd64(); q[1] = rnd64(); q[2] = rnd64();
        rom[0][0] = rnd64(); rom[0][1] = rnd64(); rom[0][2] = rnd64();
        for (int c = 1; c < 8; c++)
            for (int f = 0; f < 3; f++) rom[c][f] = rom[0][f];
        run_query("t2_tie", 1'b0, 1'b1);

        // 3: result held while the consumer stalls and a query is offered.
        random_rom();
        q[0] = rnd64(); q[1] = rnd64(); q[2] = rnd64();
        run_query("t3_hold", 1'b0, 1'b0);
        q_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q_data = rnd64();
            tick();
            chk("t3_q_ready_low", 64'(q_ready), 64'd0);
            chk("t3_rv_held", 64'(result_valid), 64'd1);
            chk("t3_class_held", 64'(result_class), 64'(exp_cls));
            chk("t3_dist_held", 64'(result_dist), 64'(exp_dist));
        end
        q_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("t3_rv_clear", 64'(result_valid), 64'd0);
        chk("t3_busy_idle", 64'(busy), 64'd0);
        q[0] = rnd64(); q[1] = rnd64(); q[2] = rom[5][2];
        run_query("t3_next", 1'b0, 1'b1);

        // 4: reset in the middle of the scan.
        q[0] = rnd64(); q[1] = rnd64(); q[2] = rnd64();
        send_query(1'b0);
        repeat (9) tick();
        chk("t4_busy_mid_scan", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4_reset");
        tick();
        rst_n = 1'b1;
        tick();
        q[0] = rom[6][0] ^ 64'hFF; q[1] = rom[6][1]; q[2] = rom[6][2];
        run_query("t4_after", 1'b0, 1'b1);

        // 5: random queries near a random class, with random bubbles.
        for (int r = 0; r < 200; r++) begin
            random_rom();
            begin
                int k;
                k = $urandom_range(0, 7);
                for (int f = 0; f < 3; f++)
                    q[f] = rom[k][f] ^ (rnd64() & rnd64() & rnd64() & rnd64());
            end
            run_query("t5_rand", 1'b1, 1'b1);
        end

`ifdef CLASS_SEARCH_MARGIN_EN
        // 6: class 2 matches exactly, class 6 is 4 bits away, others far.
        q[0] = rnd64(); q[1] = rnd64(); q[2] = rnd64();
        for (int c = 0; c < 8; c++) begin
            rom[c][0] = ~q[0];
            rom[c][1] = q[1];
            rom[c][2] = q[2];
        end
        for (int f = 0; f < 3; f++) rom[2][f] = q[f];
        rom[6][0] = q[0];
        rom[6][1] = q[1] ^ 64'h0000_0100_0001_0011;
        rom[6][2] = q[2];
        run_query("t6_margin", 1'b0, 1'b1);
        chk("t6_margin_value", 64'(exp_second - exp_dist), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
